icache_ro_dm: RTL and testbench
===============================

Name: icache_ro_dm

Overview:
- Read-only, direct-mapped instruction cache.
- Answers word-aligned fetch requests from the fetch/alignment stage on the core side: word address in, 32-bit data out, stall.
- On a miss, refills one 128-bit line from instruction memory over a request/ready handshake.
- Returns raw memory byte order. Byte swapping and half-word realignment stay in the fetch stage.

Parameters:
- LINES, 8, number of cache lines (power of two, ≥2).
- INDEX_W, 3, log2(LINES).
- TAG_W, 25, equals 28 - INDEX_W (line address bits not used as index).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- proc_read  in  1  core fetch request valid.
- proc_addr  in  30  core word address; [1:0] word-in-line, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_rdata  out  32  fetched word, raw memory order.
- proc_stall  out  1  high while the request cannot be answered this cycle.
- mem_read  out  1  line refill request.
- mem_addr  out  28  line address (proc_addr[29:2]).
- mem_rdata  in  128  refill line; word0 = [31:0], word3 = [127:96].
- mem_ready  in  1  one-cycle pulse, mem_rdata valid in that cycle.

Behaviour:
- Storage per line: valid bit, TAG_W tag, 128-bit data. There is no dirty bit and no write path.
- FSM states: IDLE, FETCH, FILL.
- IDLE:
  - hit = proc_read & valid[idx] & (tag[idx] == addr tag). It is combinational.
  - On a hit, proc_stall = 0 and proc_rdata = line word selected by proc_addr[1:0] in the same cycle. Zero-cycle hit latency.
  - On a miss (proc_read & !hit), proc_stall = 1 combinationally in the same cycle, and next state is FETCH.
  - When proc_read = 0: proc_stall = 0, proc_rdata is don't-care (drive 0), and state stays IDLE.
- FETCH:
  - mem_read = 1 and mem_addr = proc_addr[29:2], both held stable every cycle until mem_ready.
  - proc_stall = 1.
  - When mem_ready = 1: write mem_rdata into data[idx], write tag[idx], set valid[idx] = 1, and go to FILL.
  - mem_read drops to 0 in the cycle after mem_ready.
- FILL:
  - One cycle with proc_stall = 1 and mem_read = 0, then go to IDLE.
  - In IDLE the request re-evaluates as a hit and is answered.
  - Miss penalty = memory latency + 2 cycles of stall beyond the ready pulse handling.
- Requester contract: proc_addr and proc_read are held stable while proc_stall = 1. The cache does not latch the address. Any violation is a bench assertion failure, not a handled case.
- Replacement: a miss on a valid line with a different tag overwrites it unconditionally.
- mem_ready outside FETCH is ignored and changes no state.
- Reset (async, any state, including mid-FETCH):
  - All valid bits cleared, state = IDLE.
  - mem_read = 0 immediately.
  - proc_stall = 0 unless proc_read is asserted against an invalid line after release.
  - Tag and data arrays need no reset.
  - A mem_ready arriving after reset for an aborted refill is ignored (IDLE).
- Outputs during reset: mem_read = 0, mem_addr = 0, proc_rdata = 0, proc_stall = 0.
- Back-to-back fetches to the same line after a fill hit with zero stall.
- Sequential fetches crossing a line boundary (addr[1:0] 3→0) miss only if the next line is absent.

Test Plan:
- Cold miss:
  - Stimulus: after reset, proc_read = 1, proc_addr = 30'h0000_0010; memory returns mem_rdata = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA} with mem_ready 3 cycles after mem_read rises.
  - Required: stall seen the same cycle; mem_addr = 28'h000_0004; stall clears in the cycle after FILL with proc_rdata = 32'hAAAA.
- Hits in filled line:
  - Stimulus: addr 0x11, 0x12, 0x13 on consecutive cycles.
  - Required: proc_stall = 0 every cycle; proc_rdata = BBBB, CCCC, DDDD; mem_read never asserts.
- Conflict eviction:
  - Stimulus: fetch 0x10, then 0x10 + (LINES×4) = 0x30 (same index, different tag), then 0x10 again.
  - Required: three refills in total, each raising mem_read exactly once; mem_addr = 0x04, 0x0C, 0x04.
- Zero-wait memory:
  - Stimulus: mem_ready in the first FETCH cycle.
  - Required: mem_read high for exactly 1 cycle; total stall = 3 cycles (IDLE-miss, FETCH, FILL).
- Idle and stray ready:
  - Stimulus: proc_read = 0 with random addr; a stray mem_ready pulse while IDLE.
  - Required: proc_stall = 0, mem_read = 0, no valid bit changes (a later fetch to that addr still misses).
- Reset mid-fetch:
  - Stimulus: assert rst asynchronously during FETCH, then deliver mem_ready after reset is released.
  - Required: mem_read falls without waiting for a clock edge; the line stays invalid, so re-fetching the same addr misses and refills again.

Source files
------------

// File: rtl/icache_ro_dm_if.sv
// Core-fetch and refill-memory signals of the read-only instruction cache.
// The slave modport is the cache; the master modport is its environment (core and memory).
interface icache_ro_dm_if;
   logic         proc_read;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic [27:0]  mem_addr;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   modport slave (
      input  proc_read, proc_addr, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_addr
   );

   modport master (
      output proc_read, proc_addr, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_addr
   );
endinterface

// File: rtl/icache_ro_dm.sv
// Read-only direct-mapped instruction cache: zero-cycle hits, one 128-bit line refill per miss.
// The requester holds proc_addr/proc_read while stalled, so the address is never latched here.
module icache_ro_dm #(
   parameter int LINES   = 8,
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 25
) (
   input logic           clk,
   input logic           rst,
   icache_ro_dm_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [127:0]       r_data [LINES];

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [1:0]         w_word;
   logic               w_hit;
   logic               w_fill;
   logic [31:0]        w_rword;
   logic               w_stall;
   logic               w_mem_read;
   logic [27:0]        w_mem_addr;
   logic [31:0]        w_rdata;

   assign w_word = bus.proc_addr[1:0];
   assign w_idx  = bus.proc_addr[INDEX_W+1:2];
   assign w_tag  = bus.proc_addr[29:INDEX_W+2];
   assign w_hit  = bus.proc_read & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   // mem_ready only counts while a refill is outstanding; stray pulses elsewhere are dropped
   assign w_fill = (r_state == FETCH) & bus.mem_ready;

   always_comb begin
      case (w_word)
         2'd0:    w_rword = r_data[w_idx][31:0];
         2'd1:    w_rword = r_data[w_idx][63:32];
         2'd2:    w_rword = r_data[w_idx][95:64];
         default: w_rword = r_data[w_idx][127:96];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_valid <= '0;
      else if (w_fill) r_valid[w_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_idx]  <= w_tag;
         r_data[w_idx] <= bus.mem_rdata;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_stall    = 1'b0;
      w_mem_read = 1'b0;
      w_mem_addr = '0;
      w_rdata    = '0;
      case (r_state)
         IDLE: begin
            if (bus.proc_read) begin
               if (w_hit) begin
                  w_rdata = w_rword;
               end else begin
                  w_stall = 1'b1;
                  w_next  = FETCH;
               end
            end
         end
         FETCH: begin
            w_stall    = 1'b1;
            w_mem_read = 1'b1;
            w_mem_addr = bus.proc_addr[29:2];
            if (bus.mem_ready) w_next = FILL;
         end
         FILL: begin
            w_stall = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Outputs are forced quiet for as long as reset is held, independent of the clock.
   assign bus.proc_stall = w_stall    & ~rst;
   assign bus.mem_read   = w_mem_read & ~rst;
   assign bus.mem_addr   = rst ? 28'h0 : w_mem_addr;
   assign bus.proc_rdata = rst ? 32'h0 : w_rdata;
endmodule

// File: tb/tb_icache_ro_dm.sv
// Bench for icache_ro_dm: randomized fetches against a line-residency model, with a
// scoreboard queue filled by the driver and drained by a negedge monitor.
module tb_icache_ro_dm;
   localparam int LINES = 8;

   typedef struct {
      logic [31:0] data;
      int          stalls;
      int          refills;
      logic [27:0] maddr;
      int          mr;
   } exp_t;

   logic clk;
   logic rst;
   icache_ro_dm_if bus ();

   icache_ro_dm #(.LINES(LINES), .INDEX_W(3), .TAG_W(25)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [27:0] resident[int];
   int          mem_delay = 0;
   bit          resp_hold = 0;
   int          stray_req = 0;
   int          stray_ack = 0;
   int          fcnt = 0;
   int          probe_cnt = 0;
   int          probe_seen = 0;
   logic        probe_pre = 1'b0;
   logic        probe_post = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [27:0] la, input int w);
      logic [31:0] t;
      if (la == 28'h4) begin
         case (w)
            0:       return 32'h0000_AAAA;
            1:       return 32'h0000_BBBB;
            2:       return 32'h0000_CCCC;
            default: return 32'h0000_DDDD;
         endcase
      end
      t = {4'h0, la} * 32'h9E37_79B1;
      return t ^ (32'(w) * 32'h0101_0101) ^ 32'h1234_5678;
   endfunction

   function automatic logic [127:0] mem_line(input logic [27:0] la);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[32*w +: 32] = word_of(la, w);
      return l;
   endfunction

   // Memory: answers a refill mem_delay cycles after mem_read rises, or emits requested stray pulses.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_read && !resp_hold) begin
            if (fcnt == mem_delay) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mem_line(bus.mem_addr);
            end else begin
               bus.mem_ready = 1'b0;
            end
            fcnt++;
         end else if (bus.mem_read) begin
            bus.mem_ready = 1'b0;
         end else begin
            fcnt = 0;
            if (stray_req != stray_ack && !rst) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
               stray_ack++;
            end else begin
               bus.mem_ready = 1'b0;
            end
         end
      end
   end

   task check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   int          stall_cnt = 0;
   int          refills = 0;
   int          mr_cycles = 0;
   logic [27:0] maddr = '0;
   logic        prev_mr = 1'b0;
   logic        pend = 1'b0;
   logic [29:0] pend_addr = '0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (probe_cnt != probe_seen) begin
         probe_seen = probe_cnt;
         check("rst_async_mem_read", probe_pre && !probe_post, 64'({probe_pre, probe_post}), 64'h2);
      end
      if (rst) begin
         check("rst_outputs",
               {bus.proc_stall, bus.mem_read, bus.mem_addr, bus.proc_rdata} == 62'h0,
               64'({bus.proc_stall, bus.mem_read, bus.mem_addr, bus.proc_rdata}), 64'h0);
         stall_cnt = 0; refills = 0; mr_cycles = 0; pend = 1'b0;
      end else begin
         if (pend)
            check("contract", bus.proc_read && bus.proc_addr == pend_addr,
                  64'(bus.proc_addr), 64'(pend_addr));
         if (!bus.proc_read) begin
            check("idle_outputs",
                  {bus.proc_stall, bus.mem_read, bus.proc_rdata} == 34'h0 && sb.size() == 0,
                  64'({bus.proc_stall, bus.mem_read, bus.proc_rdata}), 64'h0);
            stall_cnt = 0; refills = 0; mr_cycles = 0;
         end else begin
            if (bus.mem_read) begin
               if (!prev_mr) begin
                  refills++;
                  maddr = bus.mem_addr;
               end
               mr_cycles++;
            end
            if (bus.proc_stall) begin
               stall_cnt++;
            end else if (sb.size() == 0) begin
               check("sb_empty", 1'b0, 64'(bus.proc_addr), 64'h0);
            end else begin
               mon_e = sb.pop_front();
               check("rdata", bus.proc_rdata == mon_e.data, 64'(bus.proc_rdata), 64'(mon_e.data));
               check("stall_cycles", stall_cnt == mon_e.stalls, 64'(stall_cnt), 64'(mon_e.stalls));
               check("refills", refills == mon_e.refills, 64'(refills), 64'(mon_e.refills));
               if (mon_e.refills != 0) begin
                  check("mem_addr", maddr == mon_e.maddr, 64'(maddr), 64'(mon_e.maddr));
                  check("mem_read_cycles", mr_cycles == mon_e.mr, 64'(mr_cycles), 64'(mon_e.mr));
               end
               stall_cnt = 0; refills = 0; mr_cycles = 0;
            end
         end
         pend      = bus.proc_read && bus.proc_stall;
         pend_addr = bus.proc_addr;
      end
      prev_mr = bus.mem_read;
   end

   // Expectation comes from line residency: a line is resident iff its index last filled it.
   task automatic fetch(input logic [29:0] a, input int d);
      exp_t        e;
      logic [27:0] la;
      int          idx;
      int          n;
      la  = a[29:2];
      idx = int'(la % 28'(LINES));
      e.data  = word_of(la, int'(a[1:0]));
      e.maddr = la;
      if (resident.exists(idx) && resident[idx] == la) begin
         e.stalls = 0; e.refills = 0; e.mr = 0;
      end else begin
         e.stalls = d + 3; e.refills = 1; e.mr = d + 1;
         resident[idx] = la;
      end
      sb.push_back(e);
      mem_delay     = d;
      bus.proc_read = 1'b1;
      bus.proc_addr = a;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.proc_stall && n < 100);
      if (bus.proc_stall) begin
         $display("FAIL fetch_timeout: addr %0h still stalled after %0d cycles, required answer", a, n);
         $fatal(1, "fetch timeout");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.proc_read = 1'b0;
      bus.proc_addr = 30'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [29:0] a;
      int          n;
      rst           = 1'b1;
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h10;
      repeat (3) @(posedge clk);
      #1;
      bus.proc_read = 1'b0;
      rst           = 1'b0;
      idle(2);

      fetch(30'h10, 3);
      fetch(30'h11, 1);
      fetch(30'h12, 1);
      fetch(30'h13, 1);
      fetch(30'h30, 1);
      fetch(30'h10, 2);
      fetch(30'h40, 0);
      fetch(30'h41, 0);

      stray_req++;
      idle(4);
      fetch({1'b1, 29'($urandom)}, 1);

      resp_hold     = 1'b1;
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h50;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_read && n < 20);
      if (!bus.mem_read) begin
         $display("FAIL refill_start: mem_read=%0b after %0d cycles, required 1", bus.mem_read, n);
         $fatal(1, "refill never started");
      end
      @(negedge clk);
      #1;
      probe_pre     = bus.mem_read;
      rst           = 1'b1;
      bus.proc_read = 1'b0;
      #1;
      probe_post    = bus.mem_read;
      probe_cnt++;
      resident.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      resp_hold = 1'b0;
      stray_req++;
      idle(3);
      fetch(30'h50, 2);
      fetch(30'h10, 1);

      for (int i = 0; i < 10; i++) fetch(30'h3C + 30'(i), 1);

      for (int i = 0; i < 200; i++) begin
         a = (30'($urandom_range(0, 3)) << 5) | (30'($urandom_range(0, 7)) << 2) |
             30'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a[29] = 1'b1;
         fetch(a, int'($urandom_range(0, 4)));
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) stray_req++;
            idle(int'($urandom_range(2, 4)));
         end
      end

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
